// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word plus the branch-resolution state and queue entry.
package lc3b_types;

   typedef logic [15:0] lc3b_word;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } btb_resolver_state_t;

   typedef struct packed {
      lc3b_word pc;
      lc3b_word pred;
   } btb_pred_entry_t;

endpackage

// File: rtl/pred_fifo.sv
// In-order circular queue of {pc, predicted next pc} for in-flight instructions.
module pred_fifo
   import lc3b_types::*;
#(
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  btb_pred_entry_t push_data,
   input  logic            pop,
   input  logic            clear,
   output btb_pred_entry_t head,
   output logic            full,
   output logic            empty
);

   localparam int AW = $clog2(DEPTH);

   btb_pred_entry_t mem_q [DEPTH];
   btb_pred_entry_t mem_d [DEPTH];
   logic [AW-1:0]   head_q, head_d;
   logic [AW-1:0]   tail_q, tail_d;
   logic [AW:0]     count_q, count_d;
   logic            do_push, do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign head    = mem_q[head_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Clear wins over push/pop so a same-cycle push on the wrong path is dropped.
   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (clear) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) begin
            mem_d[tail_q] = push_data;
            tail_d        = tail_q + AW'(1);
         end
         if (do_pop) begin
            head_d = head_q + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/btb_resolver.sv
// Branch resolution: compares each resolving instruction's real next PC with the
// prediction fetch used, raising a one-cycle redirect and BTB write on mismatch.
module btb_resolver
   import lc3b_types::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     fetch_valid,
   input  lc3b_word fetch_pc,
   input  lc3b_word fetch_pred,
   output logic     fetch_ready,
   input  logic     resolve_valid,
   input  logic     resolve_is_branch,
   input  logic     resolve_taken,
   input  lc3b_word resolve_target,
   output logic     mispredict,
   output lc3b_word redirect_pc,
   output logic     wb_enable,
   output lc3b_word wb_addr,
   output lc3b_word wb_target,
   output lc3b_word branch_count,
   output lc3b_word mispredict_count
);

   btb_resolver_state_t state_q, state_d;
   logic            mispredict_q, mispredict_d;
   lc3b_word        redirect_pc_q, redirect_pc_d;
   logic            wb_enable_q, wb_enable_d;
   lc3b_word        wb_addr_q, wb_addr_d;
   lc3b_word        wb_target_q, wb_target_d;
   lc3b_word        branch_count_q, branch_count_d;
   lc3b_word        mispredict_count_q, mispredict_count_d;

   btb_pred_entry_t head;
   btb_pred_entry_t push_entry;
   logic            full, empty;
   logic            do_push, resolve_fire, taken_branch, mis;
   lc3b_word        actual_pc;

   assign fetch_ready  = !full && (state_q == RUN);
   assign do_push      = fetch_valid && fetch_ready;
   assign push_entry   = '{pc: fetch_pc, pred: fetch_pred};
   assign resolve_fire = resolve_valid && !empty && (state_q == RUN);
   assign taken_branch = resolve_is_branch && resolve_taken;
   assign actual_pc    = taken_branch ? resolve_target : head.pc + 16'd2;
   assign mis          = resolve_fire && (actual_pc != head.pred);

   pred_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (do_push),
      .push_data (push_entry),
      .pop       (resolve_fire),
      .clear     (mis),
      .head      (head),
      .full      (full),
      .empty     (empty)
   );

   always_comb begin
      state_d            = state_q;
      mispredict_d       = mis;
      redirect_pc_d      = redirect_pc_q;
      wb_enable_d        = 1'b0;
      wb_addr_d          = wb_addr_q;
      wb_target_d        = wb_target_q;
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;
      case (state_q)
         RUN: begin
            if (mis) begin
               state_d            = FLUSH;
               redirect_pc_d      = actual_pc;
               mispredict_count_d = mispredict_count_q + 16'd1;
            end
            if (resolve_fire && resolve_is_branch) begin
               branch_count_d = branch_count_q + 16'd1;
            end
            // A not-taken mispredict only redirects; the BTB learns taken targets.
            if (resolve_fire && taken_branch && (head.pred != resolve_target)) begin
               wb_enable_d = 1'b1;
               wb_addr_d   = head.pc;
               wb_target_d = resolve_target;
            end
         end
         FLUSH:   state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q            <= RUN;
         mispredict_q       <= 1'b0;
         redirect_pc_q      <= '0;
         wb_enable_q        <= 1'b0;
         wb_addr_q          <= '0;
         wb_target_q        <= '0;
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
      end else begin
         state_q            <= state_d;
         mispredict_q       <= mispredict_d;
         redirect_pc_q      <= redirect_pc_d;
         wb_enable_q        <= wb_enable_d;
         wb_addr_q          <= wb_addr_d;
         wb_target_q        <= wb_target_d;
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   assign mispredict       = mispredict_q;
   assign redirect_pc      = redirect_pc_q;
   assign wb_enable        = wb_enable_q;
   assign wb_addr          = wb_addr_q;
   assign wb_target        = wb_target_q;
   assign branch_count     = branch_count_q;
   assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_btb_resolver.sv
// Scoreboard bench for btb_resolver: stimulus queues expected redirects, a monitor checks them.
module tb_btb_resolver;
   import lc3b_types::*;

   localparam int DEPTH = 4;

   logic     clk = 1'b0;
   logic     reset;
   logic     fetch_valid;
   lc3b_word fetch_pc, fetch_pred;
   logic     fetch_ready;
   logic     resolve_valid, resolve_is_branch, resolve_taken;
   lc3b_word resolve_target;
   logic     mispredict;
   lc3b_word redirect_pc;
   logic     wb_enable;
   lc3b_word wb_addr, wb_target, branch_count, mispredict_count;

   typedef struct {
      lc3b_word redirect;
      logic     wb;
      lc3b_word addr;
      lc3b_word target;
      lc3b_word bc;
      lc3b_word mc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   errors = 0;
   int   checks = 0;

   btb_resolver #(.DEPTH(DEPTH)) dut (
      .clk               (clk),
      .reset             (reset),
      .fetch_valid       (fetch_valid),
      .fetch_pc          (fetch_pc),
      .fetch_pred        (fetch_pred),
      .fetch_ready       (fetch_ready),
      .resolve_valid     (resolve_valid),
      .resolve_is_branch (resolve_is_branch),
      .resolve_taken     (resolve_taken),
      .resolve_target    (resolve_target),
      .mispredict        (mispredict),
      .redirect_pc       (redirect_pc),
      .wb_enable         (wb_enable),
      .wb_addr           (wb_addr),
      .wb_target         (wb_target),
      .branch_count      (branch_count),
      .mispredict_count  (mispredict_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic fv, input lc3b_word pc, input lc3b_word pred,
                                input logic rv, input logic rb, input logic rt, input lc3b_word tgt);
      fetch_valid       = fv;
      fetch_pc          = pc;
      fetch_pred        = pred;
      resolve_valid     = rv;
      resolve_is_branch = rb;
      resolve_taken     = rt;
      resolve_target    = tgt;
      tick();
      fetch_valid       = 1'b0;
      resolve_valid     = 1'b0;
      resolve_is_branch = 1'b0;
      resolve_taken     = 1'b0;
   endtask

   task automatic expectRedirect(input lc3b_word redirect, input logic wb, input lc3b_word addr,
                                 input lc3b_word target, input lc3b_word bc, input lc3b_word mc);
      exp_t e;
      e.redirect = redirect;
      e.wb       = wb;
      e.addr     = addr;
      e.target   = target;
      e.bc       = bc;
      e.mc       = mc;
      sb.push_back(e);
   endtask

   // Monitor: every redirect/write pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!reset && (mispredict || wb_enable)) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output: mispredict=%b wb_enable=%b redirect_pc=%h expected no pulse",
                     mispredict, wb_enable, redirect_pc);
         end else begin
            mon_e = sb.pop_front();
            checkOutput("sb_mispredict", 16'(mispredict), 16'd1);
            checkOutput("sb_redirect_pc", redirect_pc, mon_e.redirect);
            checkOutput("sb_wb_enable", 16'(wb_enable), 16'(mon_e.wb));
            if (mon_e.wb) begin
               checkOutput("sb_wb_addr", wb_addr, mon_e.addr);
               checkOutput("sb_wb_target", wb_target, mon_e.target);
            end
            checkOutput("sb_branch_count", branch_count, mon_e.bc);
            checkOutput("sb_mispredict_count", mispredict_count, mon_e.mc);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset             = 1'b1;
      fetch_valid       = 1'b0;
      fetch_pc          = '0;
      fetch_pred        = '0;
      resolve_valid     = 1'b0;
      resolve_is_branch = 1'b0;
      resolve_taken     = 1'b0;
      resolve_target    = '0;
      repeat (2) tick();
      checkOutput("rst_mispredict", 16'(mispredict), 16'd0);
      checkOutput("rst_wb_enable", 16'(wb_enable), 16'd0);
      checkOutput("rst_redirect_pc", redirect_pc, 16'h0000);
      checkOutput("rst_wb_addr", wb_addr, 16'h0000);
      checkOutput("rst_wb_target", wb_target, 16'h0000);
      checkOutput("rst_branch_count", branch_count, 16'd0);
      checkOutput("rst_mispredict_count", mispredict_count, 16'd0);
      reset = 1'b0;
      tick();
      checkOutput("rst_fetch_ready", 16'(fetch_ready), 16'd1);

      // Correctly predicted non-branch
      applyStimulus(1'b1, 16'h3000, 16'h3002, 1'b0, 1'b0, 1'b0, 16'h0);
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0);
      checkOutput("nb_mispredict", 16'(mispredict), 16'd0);
      checkOutput("nb_wb_enable", 16'(wb_enable), 16'd0);
      checkOutput("nb_fetch_ready", 16'(fetch_ready), 16'd1);

      // Taken branch predicted fall-through
      applyStimulus(1'b1, 16'h3010, 16'h3012, 1'b0, 1'b0, 1'b0, 16'h0);
      expectRedirect(16'h3040, 1'b1, 16'h3010, 16'h3040, 16'd1, 16'd1);
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b1, 16'h3040);
      checkOutput("flush_fetch_ready", 16'(fetch_ready), 16'd0);
      tick();
      checkOutput("post_flush_fetch_ready", 16'(fetch_ready), 16'd1);

      // Not-taken branch predicted taken: redirect only
      applyStimulus(1'b1, 16'h3020, 16'h3080, 1'b0, 1'b0, 1'b0, 16'h0);
      expectRedirect(16'h3022, 1'b0, 16'h0, 16'h0, 16'd2, 16'd2);
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 16'h0);
      tick();

      // Fill to 3, then 6 push/pop pairs so both pointers wrap
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 16'(16'h4000 + 2*k), 16'(16'h4100 + 2*k), 1'b0, 1'b0, 1'b0, 16'h0);
      end
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1'b1, 16'(16'h4000 + 2*(k+3)), 16'(16'h4100 + 2*(k+3)),
                       1'b1, 1'b1, 1'b1, 16'(16'h4100 + 2*k));
         checkOutput("pair_fetch_ready", 16'(fetch_ready), 16'd1);
         checkOutput("pair_mispredict", 16'(mispredict), 16'd0);
      end
      applyStimulus(1'b1, 16'h4012, 16'h4112, 1'b0, 1'b0, 1'b0, 16'h0);
      checkOutput("full_fetch_ready", 16'(fetch_ready), 16'd0);
      applyStimulus(1'b1, 16'h4F00, 16'h4F00, 1'b0, 1'b0, 1'b0, 16'h0);
      applyStimulus(1'b1, 16'h4E00, 16'h4E00, 1'b1, 1'b1, 1'b1, 16'h410C);
      checkOutput("drain_a6_mispredict", 16'(mispredict), 16'd0);
      for (int k = 7; k < 10; k++) begin
         applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b1, 16'(16'h4100 + 2*k));
         checkOutput("drain_mispredict", 16'(mispredict), 16'd0);
      end
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b1, 16'h5555);
      checkOutput("empty_resolve_branch_count", branch_count, 16'd12);
      checkOutput("empty_resolve_mispredict", 16'(mispredict), 16'd0);
      checkOutput("empty_fetch_ready", 16'(fetch_ready), 16'd1);

      // pc+2 wraps at 2^16
      applyStimulus(1'b1, 16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0);
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0);
      checkOutput("wrap_pc_mispredict", 16'(mispredict), 16'd0);
      checkOutput("wrap_pc_branch_count", branch_count, 16'd12);

      // Mispredict with concurrent push, then a wrong-path resolve during FLUSH
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 16'(16'h6000 + 2*k), 16'(16'h6002 + 2*k), 1'b0, 1'b0, 1'b0, 16'h0);
      end
      expectRedirect(16'h6100, 1'b1, 16'h6000, 16'h6100, 16'd13, 16'd3);
      applyStimulus(1'b1, 16'h6006, 16'h6008, 1'b1, 1'b1, 1'b1, 16'h6100);
      checkOutput("flush2_fetch_ready", 16'(fetch_ready), 16'd0);
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b1, 16'h6200);
      checkOutput("flush_resolve_branch_count", branch_count, 16'd13);
      checkOutput("flush_resolve_mispredict", 16'(mispredict), 16'd0);
      checkOutput("flush2_exit_fetch_ready", 16'(fetch_ready), 16'd1);
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b1, 16'h7777);
      checkOutput("cleared_branch_count", branch_count, 16'd13);
      checkOutput("cleared_mispredict_count", mispredict_count, 16'd3);

      // Asynchronous reset in the middle of a mispredict cycle
      applyStimulus(1'b1, 16'h7000, 16'h7002, 1'b0, 1'b0, 1'b0, 16'h0);
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b1, 16'h7100);
      checkOutput("pre_reset_mispredict", 16'(mispredict), 16'd1);
      reset = 1'b1;
      #1;
      checkOutput("async_rst_mispredict", 16'(mispredict), 16'd0);
      checkOutput("async_rst_wb_enable", 16'(wb_enable), 16'd0);
      checkOutput("async_rst_redirect_pc", redirect_pc, 16'h0000);
      checkOutput("async_rst_wb_addr", wb_addr, 16'h0000);
      checkOutput("async_rst_branch_count", branch_count, 16'd0);
      checkOutput("async_rst_mispredict_count", mispredict_count, 16'd0);
      tick();
      reset = 1'b0;
      tick();
      checkOutput("post_rst_fetch_ready", 16'(fetch_ready), 16'd1);
      checkOutput("post_rst_mispredict", 16'(mispredict), 16'd0);
      checkOutput("post_rst_wb_enable", 16'(wb_enable), 16'd0);

      repeat (2) tick();
      checkOutput("scoreboard_drained", 16'(sb.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/btb_resolver.md
# btb_resolver

Branch-resolution unit for the LC-3b pipeline: the write side of the branch target buffer. It tracks every fetched instruction's predicted next PC in an in-order queue, checks that prediction against the real outcome when the instruction resolves, and on a mismatch raises a one-cycle pipeline redirect and a BTB update. It sits between fetch (push side) and execute/writeback (resolve side), and drives the BTB's `wb_enable`/`wb_addr` write port.

## Interface
- `DEPTH`, default 4, sets the number of in-flight prediction entries. It must be a power of 2 and at least 2.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `fetch_valid`  in  1  fetch presents an instruction this cycle.
- `fetch_pc`  in  16 (`lc3b_word`)  PC of the fetched instruction.
- `fetch_pred`  in  16  next PC that fetch actually used (BTB target or pc+2).
- `fetch_ready`  out  1  the push is accepted when `fetch_valid && fetch_ready`.
- `resolve_valid`  in  1  the oldest in-flight instruction resolves this cycle.
- `resolve_is_branch`  in  1  that instruction is a control-flow instruction.
- `resolve_taken`  in  1  the branch was taken.
- `resolve_target`  in  16  computed target (meaningful only when taken).
- `mispredict`  out  1  one-cycle redirect/flush pulse.
- `redirect_pc`  out  16  correct next PC; valid while `mispredict` is high.
- `wb_enable`  out  1  one-cycle BTB write strobe.
- `wb_addr`  out  16  branch PC to install in the BTB.
- `wb_target`  out  16  target to install.
- `branch_count`, `mispredict_count`  out  16 each  performance counters; they wrap at 2^16.

## Operation
- The queue is a circular FIFO of {pc, pred}. It uses a log2(DEPTH)-bit head and tail plus a count of log2(DEPTH)+1 bits.
- `fetch_ready = (count != DEPTH) && (state == RUN)`.
- A push and a pop in the same cycle are both performed and the count is unchanged. When the queue is full, `fetch_ready` is low even if a pop happens in the same cycle.
- A resolve applies to the head entry.
- The actual next PC is `resolve_target` if the instruction is a branch and taken; otherwise it is `head.pc + 2`, computed mod 2^16.
- A mismatch is `actual != head.pred`.
- `resolve_valid` with an empty queue is ignored: no pop and no outputs.
- FSM with two states:
  - RUN: a resolve with a mismatch registers `mispredict=1` and `redirect_pc=actual`, clears the queue (head=tail=count=0, which also discards any push in that same cycle), and moves to FLUSH.
  - FLUSH: lasts exactly one cycle and then returns to RUN. `fetch_ready=0`, and `resolve_valid` is ignored because it belongs to the wrong path.
- A BTB write happens on any RUN resolve of a taken branch whose `head.pred != resolve_target`. It sets `wb_enable=1`, `wb_addr=head.pc`, `wb_target=resolve_target`.
- A not-taken mispredict (BTB predicted taken) raises `mispredict` but does not write the BTB.
- `branch_count` increments on every RUN resolve with `resolve_is_branch`.
- `mispredict_count` increments on every mispredict.

## Timing
- All outputs are registered except `fetch_ready`.
- `mispredict`, `redirect_pc`, `wb_enable`, `wb_addr`, `wb_target` and the counter updates appear in the cycle after the resolving edge and are high for exactly one cycle.
- The earliest push after a mispredict is accepted on the second edge after the resolving edge.
- Reset values:
  - `mispredict=0`, `wb_enable=0`.
  - `redirect_pc`, `wb_addr`, `wb_target` = 0x0000.
  - Counters = 0.
  - Queue is empty and state is RUN, so `fetch_ready=1` once reset is low.
- Asserting `reset` mid-flight or mid-FLUSH takes effect immediately (asynchronous). It drops all entries and pulses, and no write strobe leaks out after deassertion.
- Head and tail wrap from DEPTH-1 to 0.

## Structure
- `lc3b_word` comes from `lc3b_types`.
- Add to `lc3b_types`:
  - `btb_resolver_state_t` enum {RUN, FLUSH}.
  - Packed struct `btb_pred_entry_t` {lc3b_word pc; lc3b_word pred;}.
- Sub-module `pred_fifo` holds the storage, pointers and count, with `push`, `pop`, `clear`, `head`, `full`, `empty`.
- The FSM, compare logic and counters live in `btb_resolver`.

## Test plan
- Reset, then push pc=0x3000/pred=0x3002, then resolve not-branch → no `mispredict`, no `wb_enable`, queue empty, `fetch_ready=1`.
- Push pc=0x3010/pred=0x3012, then resolve taken with target 0x3040 → next cycle `mispredict=1`, `redirect_pc=0x3040`, `wb_enable=1`, `wb_addr=0x3010`, `wb_target=0x3040`, `mispredict_count=1`; `fetch_ready=0` for one cycle.
- Push pc=0x3020/pred=0x3080, then resolve not-taken → `mispredict=1`, `redirect_pc=0x3022`, `wb_enable=0`.
- Push DEPTH entries → `fetch_ready=0`. Push and pop in the same cycle at count 3 → count stays 3. Pointers wrap after 6 push/pop pairs and FIFO order is preserved.
- Push pc=0xFFFE/pred=0x0000 and resolve not-branch → no mispredict (16-bit wrap of pc+2).
- Push 3 entries, mispredict on the first, and push in the same cycle → queue empty afterwards; a resolve during FLUSH is ignored. Separately, assert `reset` in the middle of the `mispredict` cycle → outputs are 0 immediately.
